sfif_cpl_cr_rel: RTL and testbench

- Sits directly downstream of the SFIF completion-credit monitor, on the credit-return path to the PCIe core.
- The monitor emits a one-cycle `cplh_cr` pulse plus `cpld_cr` (data credits, 16-byte units) per received CplD. This block accumulates those credits.
- It releases them to the core's credit-processed interface in batches: on a threshold or on an idle timeout.
- Batching reduces processed-pulse traffic while bounding how long credits stay held.

---
 rtl/sfif_cpl_cr_rel.sv | 123 ++++++++++++
 tb/tb_sfif_cpl_cr_rel.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sfif_cpl_cr_rel.sv
// Completion-credit release batcher: accumulates CplH/CplD credits from the monitor and
// returns them to the PCIe core in bursts on a threshold or after an idle timeout.
module sfif_cpl_cr_rel #(
  parameter int HTHRESH = 8,
  parameter int DTHRESH = 32,
  parameter int TMO     = 64,
  parameter int ACC_W   = 12
) (
  input  logic             clk_125,
  input  logic             rst,
  input  logic             cplh_cr,
  input  logic [7:0]       cpld_cr,
  output logic             cplh_processed,
  output logic             cpld_processed,
  output logic [7:0]       cpld_num,
  output logic [ACC_W-1:0] pend_cplh,
  output logic [ACC_W-1:0] pend_cpld,
  output logic             cr_ovf
);

  typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [ACC_W:0]   ACC_MAX  = {1'b0, {ACC_W{1'b1}}};
  localparam logic [ACC_W-1:0] H_TH     = ACC_W'(HTHRESH);
  localparam logic [ACC_W-1:0] D_TH     = ACC_W'(DTHRESH);
  localparam logic [ACC_W-1:0] D_BURST  = ACC_W'(8'hFF);
  localparam logic [9:0]       TMO_LAST = 10'(TMO - 1);

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] sum);
    if (sum > ACC_MAX) sat_acc = ACC_MAX[ACC_W-1:0];
    else               sat_acc = sum[ACC_W-1:0];
  endfunction

  state_t           state_r, state_s;
  logic [ACC_W-1:0] acc_h_r, acc_d_r;
  logic [9:0]       timer_r, timer_s;
  logic             cr_ovf_r, cplh_proc_r, cpld_proc_r;
  logic [7:0]       cpld_num_r;
  logic             rel_h_s, held_s, ovf_s;
  logic [7:0]       rel_d_s;
  logic [ACC_W:0]   sum_h_s, sum_d_s;

  // Release amounts for this edge and the saturating accumulator sums
  always_comb begin
    rel_h_s = 1'b0;
    rel_d_s = 8'd0;
    if (state_r == FLUSH) begin
      rel_h_s = (acc_h_r != '0);
      if (acc_d_r > D_BURST) rel_d_s = 8'hFF;
      else                   rel_d_s = acc_d_r[7:0];
    end else begin
      rel_h_s = 1'b0;
      rel_d_s = 8'd0;
    end
    held_s  = (acc_h_r != '0) || (acc_d_r != '0);
    // Release never exceeds the held amount, so the subtraction cannot wrap
    sum_h_s = {1'b0, acc_h_r} + (ACC_W+1)'(cplh_cr) - (ACC_W+1)'(rel_h_s);
    sum_d_s = {1'b0, acc_d_r} + (ACC_W+1)'(cpld_cr) - (ACC_W+1)'(rel_d_s);
    ovf_s   = (sum_h_s > ACC_MAX) || (sum_d_s > ACC_MAX);
  end

  // Next-state and idle-timer logic
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    case (state_r)
      IDLE: begin
        if ((acc_h_r >= H_TH) || (acc_d_r >= D_TH) || ((timer_r == TMO_LAST) && held_s)) begin
          state_s = FLUSH;
          timer_s = 10'd0;
        end else if (held_s) begin
          timer_s = timer_r + 10'd1;
        end else begin
          timer_s = 10'd0;
        end
      end
      FLUSH: begin
        timer_s = 10'd0;
        // Exit ignores this edge's arrivals; they are left for the IDLE rules
        if (((acc_h_r - ACC_W'(rel_h_s)) == '0) && ((acc_d_r - ACC_W'(rel_d_s)) == '0)) begin
          state_s = IDLE;
        end else begin
          state_s = FLUSH;
        end
      end
      default: begin
        state_s = IDLE;
        timer_s = 10'd0;
      end
    endcase
  end

  // State, accumulators and registered credit-return outputs
  always_ff @(posedge clk_125) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_h_r     <= '0;
      acc_d_r     <= '0;
      timer_r     <= 10'd0;
      cr_ovf_r    <= 1'b0;
      cplh_proc_r <= 1'b0;
      cpld_proc_r <= 1'b0;
      cpld_num_r  <= 8'd0;
    end else begin
      state_r     <= state_s;
      acc_h_r     <= sat_acc(sum_h_s);
      acc_d_r     <= sat_acc(sum_d_s);
      timer_r     <= timer_s;
      cr_ovf_r    <= cr_ovf_r | ovf_s;
      cplh_proc_r <= rel_h_s;
      cpld_proc_r <= (rel_d_s != 8'd0);
      cpld_num_r  <= rel_d_s;
    end
  end

  assign cplh_processed = cplh_proc_r;
  assign cpld_processed = cpld_proc_r;
  assign cpld_num       = cpld_num_r;
  assign pend_cplh      = acc_h_r;
  assign pend_cpld      = acc_d_r;
  assign cr_ovf         = cr_ovf_r;

endmodule

// File: tb/tb_sfif_cpl_cr_rel.sv
// Self-checking bench for sfif_cpl_cr_rel: vector table for the threshold flows plus
// directed sequences for reset, timeout, overlap with an active flush and saturation.
module tb_sfif_cpl_cr_rel;
  localparam int TMO = 64;

  logic        clk_125 = 1'b0;
  always #4 clk_125 = ~clk_125;

  logic        rst = 1'b1, cplh_cr = 1'b0;
  logic [7:0]  cpld_cr = 8'd0;
  logic        cplh_processed, cpld_processed, cr_ovf;
  logic [7:0]  cpld_num;
  logic [11:0] pend_cplh, pend_cpld;

  logic        s_rst = 1'b1, s_cplh_cr = 1'b0;
  logic [7:0]  s_cpld_cr = 8'd0;
  logic        s_cplh_processed, s_cpld_processed, s_cr_ovf;
  logic [7:0]  s_cpld_num;
  logic [7:0]  s_pend_cplh, s_pend_cpld;

  sfif_cpl_cr_rel #(.HTHRESH(8), .DTHRESH(32), .TMO(TMO), .ACC_W(12)) dut (
    .clk_125(clk_125), .rst(rst), .cplh_cr(cplh_cr), .cpld_cr(cpld_cr),
    .cplh_processed(cplh_processed), .cpld_processed(cpld_processed), .cpld_num(cpld_num),
    .pend_cplh(pend_cplh), .pend_cpld(pend_cpld), .cr_ovf(cr_ovf));

  sfif_cpl_cr_rel #(.HTHRESH(8), .DTHRESH(32), .TMO(TMO), .ACC_W(8)) dut_sat (
    .clk_125(clk_125), .rst(s_rst), .cplh_cr(s_cplh_cr), .cpld_cr(s_cpld_cr),
    .cplh_processed(s_cplh_processed), .cpld_processed(s_cpld_processed), .cpld_num(s_cpld_num),
    .pend_cplh(s_pend_cplh), .pend_cpld(s_pend_cpld), .cr_ovf(s_cr_ovf));

  typedef struct {
    logic        r;
    logic        h;
    logic [7:0]  d;
    logic        ph;
    logic        pd;
    logic [7:0]  num;
    logic [11:0] eh;
    logic [11:0] ed;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   ret_h  = 0;
  int   ret_d  = 0;

  function automatic void add_vec(int r, int h, int d, int ph, int pd, int num, int eh, int ed);
    vec_t v;
    v.r = 1'(r); v.h = 1'(h); v.d = 8'(d);
    v.ph = 1'(ph); v.pd = 1'(pd); v.num = 8'(num);
    v.eh = 12'(eh); v.ed = 12'(ed);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_125);
    #1;
    ret_h += int'(cplh_processed);
    ret_d += int'(cpld_num);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_ph"}, 32'(cplh_processed), 32'd0);
    chk({name, "_pd"}, 32'(cpld_processed), 32'd0);
    chk({name, "_num"}, 32'(cpld_num), 32'd0);
    chk({name, "_pend_h"}, 32'(pend_cplh), 32'd0);
    chk({name, "_pend_d"}, 32'(pend_cpld), 32'd0);
  endtask

  initial begin
    int  n;
    bit  found;
    bit  seen;

    // Header threshold: 8 headers, 2 data each -> flush at the 9th edge, pulses from the 10th
    add_vec(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add_vec(0, 1, 2, 0, 0, 0, k, 2 * k);
    add_vec(0, 0, 0, 0, 0, 0, 8, 16);
    add_vec(0, 0, 0, 1, 1, 16, 7, 0);
    for (int k = 6; k >= 0; k--) add_vec(0, 0, 0, 1, 0, 0, k, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0);
    // Data split: 200 then 100 -> 255 then 45, two header returns
    add_vec(1, 0, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 200, 0, 0, 0, 1, 200);
    add_vec(0, 1, 100, 0, 0, 0, 2, 300);
    add_vec(0, 0, 0, 1, 1, 255, 1, 45);
    add_vec(0, 0, 0, 1, 1, 45, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held two cycles with active inputs, then three idle cycles
    rst = 1'b1; cplh_cr = 1'b1; cpld_cr = 8'h10;
    tick(); tick();
    chk_quiet("rst");
    chk("rst_ovf", 32'(cr_ovf), 32'd0);
    rst = 1'b0; cplh_cr = 1'b0; cpld_cr = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet($sformatf("post_rst%0d", i));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; cplh_cr = vecs[i].h; cpld_cr = vecs[i].d;
      tick();
      chk($sformatf("v%0d_ph", i), 32'(cplh_processed), 32'(vecs[i].ph));
      chk($sformatf("v%0d_pd", i), 32'(cpld_processed), 32'(vecs[i].pd));
      chk($sformatf("v%0d_num", i), 32'(cpld_num), 32'(vecs[i].num));
      chk($sformatf("v%0d_pend_h", i), 32'(pend_cplh), 32'(vecs[i].eh));
      chk($sformatf("v%0d_pend_d", i), 32'(pend_cpld), 32'(vecs[i].ed));
      chk($sformatf("v%0d_ovf", i), 32'(cr_ovf), 32'd0);
    end
    rst = 1'b0; cplh_cr = 1'b0; cpld_cr = 8'd0;

    // Reset in the middle of a flush drops held credits and suppresses the next pulse
    rst = 1'b1; tick(); rst = 1'b0;
    cplh_cr = 1'b1; cpld_cr = 8'd2;
    for (int i = 0; i < 8; i++) tick();
    cplh_cr = 1'b0; cpld_cr = 8'd0;
    tick(); tick();
    chk("midrst_first_pulse", 32'(cplh_processed), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_quiet("midrst_at");
    tick();
    chk_quiet("midrst_after");

    // Timeout: one credit, then idle; first pulse at the TMO+2-th edge counting the input edge
    rst = 1'b1; tick(); rst = 1'b0;
    cplh_cr = 1'b1; cpld_cr = 8'd4;
    tick();
    n = 1;
    found = cplh_processed;
    cplh_cr = 1'b0; cpld_cr = 8'd0;
    while (!found && n < 200) begin
      tick();
      n++;
      found = cplh_processed;
    end
    chk("tmo_found", 32'(found), 32'd1);
    chk("tmo_latency", 32'(n), 32'(TMO + 2));
    chk("tmo_pd", 32'(cpld_processed), 32'd1);
    chk("tmo_num", 32'(cpld_num), 32'd4);
    tick();
    chk_quiet("tmo_after");

    // Credits keep arriving while a flush is draining: nothing may be lost
    rst = 1'b1; tick(); rst = 1'b0;
    ret_h = 0; ret_d = 0; seen = 1'b0;
    cplh_cr = 1'b1; cpld_cr = 8'd8;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cplh_processed) seen = 1'b1;
    end
    cplh_cr = 1'b0; cpld_cr = 8'd0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (pend_cplh == 12'd0 && pend_cpld == 12'd0 && !cplh_processed && !cpld_processed)
        found = 1'b1;
    end
    chk("sim_drained", 32'(found), 32'd1);
    chk("sim_overlap", 32'(seen), 32'd1);
    chk("sim_hdr_total", 32'(ret_h), 32'd30);
    chk("sim_data_total", 32'(ret_d), 32'd240);
    chk("sim_pend_h", 32'(pend_cplh), 32'd0);
    chk("sim_pend_d", 32'(pend_cpld), 32'd0);

    // Saturation on the 8-bit instance: 255 + 255 clamps and latches the overflow flag
    s_rst = 1'b1; tick(); s_rst = 1'b0;
    s_cpld_cr = 8'd255;
    tick();
    chk("sat_first_pend", 32'(s_pend_cpld), 32'd255);
    chk("sat_first_ovf", 32'(s_cr_ovf), 32'd0);
    tick();
    chk("sat_pend", 32'(s_pend_cpld), 32'd255);
    chk("sat_ovf", 32'(s_cr_ovf), 32'd1);
    s_cpld_cr = 8'd0;
    tick();
    chk("sat_num", 32'(s_cpld_num), 32'd255);
    chk("sat_drain_pend", 32'(s_pend_cpld), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_ovf_sticky", 32'(s_cr_ovf), 32'd1);
    s_rst = 1'b1; tick(); s_rst = 1'b0;
    chk("sat_ovf_rst", 32'(s_cr_ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
